tcm_port_arb: RTL and testbench
===============================

Name: tcm_port_arb

Overview:
- Arbiter that shares one port of the dual-port 128KB TCM (16384 x 64-bit words, 1-cycle synchronous read, read-first, byte write enables) between two requesters.
- Requester A is the core data path (LSU). Requester B is the external bus slave (loader/debug/DMA).
- A has fixed priority. A starvation counter guarantees B forward progress.
- Each requester gets its own registered response channel, so read data returns to the owner of the access.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles B may wait while A wins before B is forced to win; legal range 1..255.
- CNT_W, 8: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk_i  in  1  clock; all state on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- a_valid_i  in  1  requester A request valid.
- a_addr_i  in  14  A word address.
- a_data_i  in  64  A write data.
- a_wr_i  in  8  A byte write enables; 0 means read.
- a_accept_o  out  1  A request taken this cycle (combinational).
- a_resp_valid_o  out  1  A response (read data or write ack) valid.
- a_resp_data_o  out  64  A read data.
- b_valid_i, b_addr_i, b_data_i, b_wr_i  in  1/14/64/8  requester B, same meaning as A.
- b_accept_o  out  1  B request taken this cycle.
- b_resp_valid_o  out  1  B response valid.
- b_resp_data_o  out  64  B read data.
- ram_addr_o  out  14  to RAM port address.
- ram_data_o  out  64  to RAM port write data.
- ram_wr_o  out  8  to RAM port byte enables.
- ram_data_i  in  64  RAM port registered read data.

Behaviour:
- Grant logic is combinational, one grant per cycle, no idle bubble between grants.
- force_b = b_valid_i && (starve_cnt == STARVE_LIMIT).
- grant_b = b_valid_i && (!a_valid_i || force_b).
- grant_a = a_valid_i && !grant_b.
- a_accept_o = grant_a; b_accept_o = grant_b. Requesters hold valid/addr/data/wr stable until accepted.
- RAM drive:
  - on grant, ram_addr_o/ram_data_o/ram_wr_o = the granted requester's fields.
  - with no grant, ram_wr_o = 0 and ram_addr_o/ram_data_o = 0. No spurious writes are ever issued.
- Starvation counter starve_cnt (CNT_W bits):
  - cleared when b_valid_i=0 or grant_b=1;
  - else incremented when b_valid_i && grant_a, saturating at STARVE_LIMIT.
- Response tracking:
  - registered flags resp_a_q and resp_b_q set the cycle after grant_a / grant_b respectively, else cleared.
  - a_resp_valid_o = resp_a_q; b_resp_valid_o = resp_b_q. Latency is exactly 1 cycle after accept, for reads and writes alike.
  - At most one of the two flags is high in any cycle.
- Response data:
  - a_resp_data_o = resp_a_q ? ram_data_i : 0; b_resp_data_o likewise with resp_b_q.
  - A write returns the pre-write word (read-first); requesters ignore data on write acks.
- Responses have no backpressure. Requesters must sink a response in the cycle it is presented.
- Back-to-back accepts are allowed. A read following a write to the same address sees the new data.
- Reset (async assert, any time including mid-transfer):
  - starve_cnt = 0, resp_a_q = 0, resp_b_q = 0, so all resp_valid and resp_data are 0.
  - While rst_i is high, grants are suppressed: accept outputs and ram_wr_o are 0.
  - A response in flight at reset is dropped.
  - First grant is possible on the first clock edge after deassertion.
- Simultaneous A and B with starve_cnt < STARVE_LIMIT: A wins. At the limit: B wins and the counter clears.
- No deadlock or starvation: worst-case B wait is STARVE_LIMIT cycles. A wait is at most 1 cycle per forced B grant.

Test Plan:
- Solo A: A write addr 0x0010 data 0x1122334455667788 wr 0xFF, then read 0x0010 -> accept same cycle each; read response 1 cycle later on a_resp_data_o = 0x1122334455667788; b_resp_valid_o stays 0.
- Byte enables: word at 0x0020 = 0; B write data 0xFFFF...FF wr 0x0F; A read 0x0020 -> A gets 0x00000000FFFFFFFF.
- Contention, STARVE_LIMIT=4: A and B valid continuously -> grant pattern A,A,A,A,B repeating; starve_cnt visibly 0..4 then 0; every response routed to the correct owner.
- B alone while A idle -> B accepted immediately every cycle; starve_cnt stays 0.
- Routing: A read 0x0100 and B read 0x0200 interleaved on alternate cycles, with pre-loaded distinct values -> each resp_valid pulses only for its own accepts, with correct data, one cycle after accept.
- Reset mid-op: assert rst_i asynchronously the cycle after an A read accept -> a_resp_valid_o drops to 0 immediately, no RAM write occurs during reset, starve_cnt = 0; normal arbitration resumes on the first edge after release.

Source files
------------

// File: rtl/tcm_port_arb.sv
// Two-requester arbiter for one TCM port: A (LSU) has fixed priority and B (bus
// slave) is guaranteed progress by a starvation counter. Each side gets its own response channel.
module tcm_port_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        a_valid_i,
  input  logic [13:0] a_addr_i,
  input  logic [63:0] a_data_i,
  input  logic [7:0]  a_wr_i,
  output logic        a_accept_o,
  output logic        a_resp_valid_o,
  output logic [63:0] a_resp_data_o,

  input  logic        b_valid_i,
  input  logic [13:0] b_addr_i,
  input  logic [63:0] b_data_i,
  input  logic [7:0]  b_wr_i,
  output logic        b_accept_o,
  output logic        b_resp_valid_o,
  output logic [63:0] b_resp_data_o,

  output logic [13:0] ram_addr_o,
  output logic [63:0] ram_data_o,
  output logic [7:0]  ram_wr_o,
  input  logic [63:0] ram_data_i
);

  localparam int                 DATA_W = 64;
  localparam int                 ADDR_W = 14;
  localparam int                 BE_W   = DATA_W / 8;
  localparam logic [CNT_W-1:0]   LIMIT  = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_b;
  logic             grant_a;
  logic             grant_b;
  logic             resp_a_q;
  logic             resp_b_q;

  // Saturating advance of the B wait counter; cleared whenever B is idle or served.
  function automatic logic [CNT_W-1:0] next_starve(
    input logic [CNT_W-1:0] cnt,
    input logic             b_valid,
    input logic             b_granted,
    input logic             a_granted
  );
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (!b_valid || b_granted) begin
      nxt = '0;
    end else if (a_granted) begin
      nxt = (cnt >= LIMIT) ? LIMIT : cnt + CNT_W'(1);
    end
    return nxt;
  endfunction

  // Response data is forced to zero outside its valid cycle so the other
  // requester's read data never appears on this channel.
  function automatic logic [DATA_W-1:0] gate_data(
    input logic              vld,
    input logic [DATA_W-1:0] data
  );
    return vld ? data : '0;
  endfunction

  // Grant stage: combinational, one winner per cycle, suppressed during reset.
  always_comb begin
    force_b = b_valid_i && (starve_cnt == LIMIT);
    grant_b = !rst_i && b_valid_i && (!a_valid_i || force_b);
    grant_a = !rst_i && a_valid_i && !grant_b;
  end

  assign a_accept_o = grant_a;
  assign b_accept_o = grant_b;

  always_comb begin
    ram_addr_o = '0;
    ram_data_o = '0;
    ram_wr_o   = '0;
    if (grant_a) begin
      ram_addr_o = a_addr_i;
      ram_data_o = a_data_i;
      ram_wr_o   = a_wr_i;
    end else if (grant_b) begin
      ram_addr_o = b_addr_i;
      ram_data_o = b_data_i;
      ram_wr_o   = b_wr_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= next_starve(starve_cnt, b_valid_i, grant_b, grant_a);
    end
  end

  // Response stage: the RAM read data lands one cycle after the grant, so the
  // owner flag is just the grant delayed by one clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_a_q <= 1'b0;
      resp_b_q <= 1'b0;
    end else begin
      resp_a_q <= grant_a;
      resp_b_q <= grant_b;
    end
  end

  assign a_resp_valid_o = resp_a_q;
  assign b_resp_valid_o = resp_b_q;
  assign a_resp_data_o  = gate_data(resp_a_q, ram_data_i);
  assign b_resp_data_o  = gate_data(resp_b_q, ram_data_i);

  logic unused_w;
  assign unused_w = (ADDR_W != 14) || (BE_W != 8);

endmodule

// File: tb/tb_tcm_port_arb.sv
// Directed bench for tcm_port_arb with a behavioural read-first, byte-enabled TCM
// on the RAM port; each scenario task checks its own expected values.
module tb_tcm_port_arb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        a_valid_i = 1'b0;
  logic [13:0] a_addr_i = '0;
  logic [63:0] a_data_i = '0;
  logic [7:0]  a_wr_i = '0;
  logic        a_accept_o, a_resp_valid_o;
  logic [63:0] a_resp_data_o;
  logic        b_valid_i = 1'b0;
  logic [13:0] b_addr_i = '0;
  logic [63:0] b_data_i = '0;
  logic [7:0]  b_wr_i = '0;
  logic        b_accept_o, b_resp_valid_o;
  logic [63:0] b_resp_data_o;
  logic [13:0] ram_addr_o;
  logic [63:0] ram_data_o;
  logic [7:0]  ram_wr_o;
  logic [63:0] ram_data_i;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] A_VAL = 64'hA5A5_0100_DEAD_BEEF;
  localparam logic [63:0] B_VAL = 64'h5A5A_0200_CAFE_F00D;

  tcm_port_arb #(.STARVE_LIMIT(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_wr_i(a_wr_i),
    .a_accept_o(a_accept_o), .a_resp_valid_o(a_resp_valid_o), .a_resp_data_o(a_resp_data_o),
    .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_wr_i(b_wr_i),
    .b_accept_o(b_accept_o), .b_resp_valid_o(b_resp_valid_o), .b_resp_data_o(b_resp_data_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_wr_o(ram_wr_o),
    .ram_data_i(ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural TCM: 1-cycle synchronous read, read-first, byte write enables.
  logic [63:0] mem [0:16383];
  always @(posedge clk_i) begin
    ram_data_i <= mem[ram_addr_o];
    for (int i = 0; i < 8; i++)
      if (ram_wr_o[i]) mem[ram_addr_o][i*8 +: 8] <= ram_data_o[i*8 +: 8];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d required=finish", n_checks);
    $fatal(1);
  end

  task automatic drive_a(input logic v, input logic [13:0] ad, input logic [63:0] d, input logic [7:0] w);
    a_valid_i = v; a_addr_i = ad; a_data_i = d; a_wr_i = w;
  endtask

  task automatic drive_b(input logic v, input logic [13:0] ad, input logic [63:0] d, input logic [7:0] w);
    b_valid_i = v; b_addr_i = ad; b_data_i = d; b_wr_i = w;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    drive_a(1'b1, 14'h3FF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    drive_b(1'b1, 14'h3FE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    #1;
    n_checks++; if (a_accept_o !== 1'b0) begin n_fail++; $display("FAIL rst_a_accept got=%b exp=0", a_accept_o); end
    n_checks++; if (b_accept_o !== 1'b0) begin n_fail++; $display("FAIL rst_b_accept got=%b exp=0", b_accept_o); end
    n_checks++; if (ram_wr_o !== 8'h00) begin n_fail++; $display("FAIL rst_ram_wr got=%h exp=00", ram_wr_o); end
    n_checks++; if (dut.starve_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_starve got=%0d exp=0", dut.starve_cnt); end
    @(posedge clk_i); #1;
    n_checks++; if ({a_resp_valid_o, b_resp_valid_o} !== 2'b00) begin n_fail++; $display("FAIL rst_resp_valid got=%b exp=00", {a_resp_valid_o, b_resp_valid_o}); end
    n_checks++; if ({a_resp_data_o, b_resp_data_o} !== 128'd0) begin n_fail++; $display("FAIL rst_resp_data got=%h exp=0", {a_resp_data_o, b_resp_data_o}); end
    @(posedge clk_i); #1;
    n_checks++; if (mem[14'h3FF] !== 64'd0 || mem[14'h3FE] !== 64'd0) begin n_fail++; $display("FAIL rst_no_write got=%h/%h exp=0", mem[14'h3FF], mem[14'h3FE]); end
    @(negedge clk_i);
    drive_a(1'b0, '0, '0, '0);
    drive_b(1'b0, '0, '0, '0);
    rst_i = 1'b0;
  endtask

  task automatic test_solo_a();
    @(negedge clk_i);
    drive_a(1'b1, 14'h0010, 64'h1122_3344_5566_7788, 8'hFF);
    #1;
    n_checks++; if ({a_accept_o, b_accept_o} !== 2'b10) begin n_fail++; $display("FAIL solo_wr_accept got=%b exp=10", {a_accept_o, b_accept_o}); end
    n_checks++; if (ram_wr_o !== 8'hFF || ram_addr_o !== 14'h0010) begin n_fail++; $display("FAIL solo_wr_ram got=%h@%h exp=ff@0010", ram_wr_o, ram_addr_o); end
    @(posedge clk_i); #1;
    n_checks++; if ({a_resp_valid_o, b_resp_valid_o} !== 2'b10) begin n_fail++; $display("FAIL solo_wr_ack got=%b exp=10", {a_resp_valid_o, b_resp_valid_o}); end
    @(negedge clk_i);
    drive_a(1'b1, 14'h0010, '0, 8'h00);
    #1;
    n_checks++; if (a_accept_o !== 1'b1 || ram_wr_o !== 8'h00) begin n_fail++; $display("FAIL solo_rd_accept got=%b/%h exp=1/00", a_accept_o, ram_wr_o); end
    @(posedge clk_i); #1;
    n_checks++; if (a_resp_valid_o !== 1'b1 || a_resp_data_o !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL solo_rd_data got=%b/%h exp=1/1122334455667788", a_resp_valid_o, a_resp_data_o); end
    n_checks++; if (b_resp_valid_o !== 1'b0 || b_resp_data_o !== 64'd0) begin n_fail++; $display("FAIL solo_b_quiet got=%b/%h exp=0/0", b_resp_valid_o, b_resp_data_o); end
    @(negedge clk_i);
    drive_a(1'b0, '0, '0, '0);
    #1;
    n_checks++; if (ram_wr_o !== 8'h00 || ram_addr_o !== 14'd0 || ram_data_o !== 64'd0) begin n_fail++; $display("FAIL idle_ram got=%h/%h/%h exp=0/0/0", ram_wr_o, ram_addr_o, ram_data_o); end
    @(posedge clk_i); #1;
    n_checks++; if (a_resp_valid_o !== 1'b0 || a_resp_data_o !== 64'd0) begin n_fail++; $display("FAIL solo_resp_drop got=%b/%h exp=0/0", a_resp_valid_o, a_resp_data_o); end
  endtask

  task automatic test_byte_en();
    @(negedge clk_i);
    drive_b(1'b1, 14'h0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    #1;
    n_checks++; if ({a_accept_o, b_accept_o} !== 2'b01 || ram_wr_o !== 8'h0F) begin n_fail++; $display("FAIL be_b_accept got=%b/%h exp=01/0f", {a_accept_o, b_accept_o}, ram_wr_o); end
    @(posedge clk_i); #1;
    n_checks++; if ({a_resp_valid_o, b_resp_valid_o} !== 2'b01) begin n_fail++; $display("FAIL be_b_ack got=%b exp=01", {a_resp_valid_o, b_resp_valid_o}); end
    @(negedge clk_i);
    drive_b(1'b0, '0, '0, '0);
    drive_a(1'b1, 14'h0020, '0, 8'h00);
    @(posedge clk_i); #1;
    n_checks++; if (a_resp_valid_o !== 1'b1 || a_resp_data_o !== 64'h0000_0000_FFFF_FFFF) begin n_fail++; $display("FAIL be_read got=%b/%h exp=1/00000000ffffffff", a_resp_valid_o, a_resp_data_o); end
    @(negedge clk_i);
    drive_a(1'b0, '0, '0, '0);
  endtask

  task automatic test_contention();
    @(negedge clk_i);
    drive_a(1'b1, 14'h0100, '0, 8'h00);
    drive_b(1'b1, 14'h0200, '0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      logic exp_b;
      exp_b = (i % 5 == 4);
      #1;
      n_checks++; if (dut.starve_cnt !== 8'(i % 5)) begin n_fail++; $display("FAIL cont_starve[%0d] got=%0d exp=%0d", i, dut.starve_cnt, i % 5); end
      n_checks++; if ({a_accept_o, b_accept_o} !== {!exp_b, exp_b}) begin n_fail++; $display("FAIL cont_grant[%0d] got=%b exp=%b", i, {a_accept_o, b_accept_o}, {!exp_b, exp_b}); end
      @(posedge clk_i); #1;
      n_checks++;
      if ({a_resp_valid_o, b_resp_valid_o} !== {!exp_b, exp_b} ||
          a_resp_data_o !== (exp_b ? 64'd0 : A_VAL) || b_resp_data_o !== (exp_b ? B_VAL : 64'd0)) begin
        n_fail++;
        $display("FAIL cont_resp[%0d] got=%b %h %h exp=%b", i, {a_resp_valid_o, b_resp_valid_o}, a_resp_data_o, b_resp_data_o, {!exp_b, exp_b});
      end
      @(negedge clk_i);
    end
    drive_a(1'b0, '0, '0, '0);
    drive_b(1'b0, '0, '0, '0);
  endtask

  task automatic test_b_alone();
    @(negedge clk_i);
    drive_b(1'b1, 14'h0200, '0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (b_accept_o !== 1'b1 || a_accept_o !== 1'b0) begin n_fail++; $display("FAIL balone_accept[%0d] got=%b exp=01", i, {a_accept_o, b_accept_o}); end
      n_checks++; if (dut.starve_cnt !== 8'd0) begin n_fail++; $display("FAIL balone_starve[%0d] got=%0d exp=0", i, dut.starve_cnt); end
      @(posedge clk_i); #1;
      n_checks++; if (b_resp_valid_o !== 1'b1 || b_resp_data_o !== B_VAL) begin n_fail++; $display("FAIL balone_resp[%0d] got=%b/%h exp=1/%h", i, b_resp_valid_o, b_resp_data_o, B_VAL); end
      @(negedge clk_i);
    end
    drive_b(1'b0, '0, '0, '0);
  endtask

  task automatic test_routing();
    @(negedge clk_i);
    for (int i = 0; i < 6; i++) begin
      logic is_b;
      is_b = i[0];
      if (is_b) begin drive_a(1'b0, '0, '0, '0); drive_b(1'b1, 14'h0200, '0, 8'h00); end
      else      begin drive_b(1'b0, '0, '0, '0); drive_a(1'b1, 14'h0100, '0, 8'h00); end
      #1;
      n_checks++; if ({a_accept_o, b_accept_o} !== {!is_b, is_b}) begin n_fail++; $display("FAIL route_accept[%0d] got=%b exp=%b", i, {a_accept_o, b_accept_o}, {!is_b, is_b}); end
      @(posedge clk_i); #1;
      n_checks++;
      if ({a_resp_valid_o, b_resp_valid_o} !== {!is_b, is_b} ||
          a_resp_data_o !== (is_b ? 64'd0 : A_VAL) || b_resp_data_o !== (is_b ? B_VAL : 64'd0)) begin
        n_fail++;
        $display("FAIL route_resp[%0d] got=%b %h %h exp=%b", i, {a_resp_valid_o, b_resp_valid_o}, a_resp_data_o, b_resp_data_o, {!is_b, is_b});
      end
      @(negedge clk_i);
    end
    drive_a(1'b0, '0, '0, '0);
    drive_b(1'b0, '0, '0, '0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    drive_a(1'b1, 14'h0040, 64'h0123_4567_89AB_CDEF, 8'hFF);
    @(posedge clk_i); #1;
    n_checks++; if (a_resp_valid_o !== 1'b1 || a_resp_data_o !== 64'd0) begin n_fail++; $display("FAIL b2b_wr_old got=%b/%h exp=1/0", a_resp_valid_o, a_resp_data_o); end
    @(negedge clk_i);
    drive_a(1'b1, 14'h0040, '0, 8'h00);
    @(posedge clk_i); #1;
    n_checks++; if (a_resp_valid_o !== 1'b1 || a_resp_data_o !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL b2b_rd_new got=%b/%h exp=1/0123456789abcdef", a_resp_valid_o, a_resp_data_o); end
    @(negedge clk_i);
    drive_a(1'b0, '0, '0, '0);
  endtask

  task automatic test_reset_midop();
    @(negedge clk_i);
    drive_a(1'b1, 14'h0100, '0, 8'h00);
    drive_b(1'b1, 14'h0300, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    #1;
    n_checks++; if (a_accept_o !== 1'b1 || dut.starve_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_pre_accept got=%b/%0d exp=1/0", a_accept_o, dut.starve_cnt); end
    @(posedge clk_i); #1;
    n_checks++; if (dut.starve_cnt !== 8'd1) begin n_fail++; $display("FAIL mid_starve_before got=%0d exp=1", dut.starve_cnt); end
    drive_a(1'b1, 14'h0300, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    rst_i = 1'b1;
    #1;
    n_checks++; if (a_resp_valid_o !== 1'b0 || a_resp_data_o !== 64'd0) begin n_fail++; $display("FAIL mid_resp_drop got=%b/%h exp=0/0", a_resp_valid_o, a_resp_data_o); end
    n_checks++; if (dut.starve_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_starve got=%0d exp=0", dut.starve_cnt); end
    n_checks++; if ({a_accept_o, b_accept_o} !== 2'b00 || ram_wr_o !== 8'h00) begin n_fail++; $display("FAIL mid_grants got=%b/%h exp=00/00", {a_accept_o, b_accept_o}, ram_wr_o); end
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++; if (mem[14'h0300] !== 64'd0) begin n_fail++; $display("FAIL mid_no_write got=%h exp=0", mem[14'h0300]); end
    @(negedge clk_i);
    drive_b(1'b0, '0, '0, '0);
    drive_a(1'b1, 14'h0100, '0, 8'h00);
    rst_i = 1'b0;
    #1;
    n_checks++; if (a_accept_o !== 1'b1) begin n_fail++; $display("FAIL mid_resume_accept got=%b exp=1", a_accept_o); end
    @(posedge clk_i); #1;
    n_checks++; if (a_resp_valid_o !== 1'b1 || a_resp_data_o !== A_VAL) begin n_fail++; $display("FAIL mid_resume_resp got=%b/%h exp=1/%h", a_resp_valid_o, a_resp_data_o, A_VAL); end
    @(negedge clk_i);
    drive_a(1'b0, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 64'd0;
    mem[14'h0100] = A_VAL;
    mem[14'h0200] = B_VAL;
    test_reset();
    test_solo_a();
    test_byte_en();
    test_contention();
    test_b_alone();
    test_routing();
    test_back_to_back();
    test_reset_midop();
    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
